m_muldiv_iter: RTL



---
 rtl/m_muldiv_iter_if.sv | 23 ++
 rtl/m_muldiv_iter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/m_muldiv_iter_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
interface m_muldiv_iter_if #(
   parameter int XLEN = 32
);
   logic            w_start;
   logic [2:0]      w_fct3;
   logic [XLEN-1:0] w_in1;
   logic [XLEN-1:0] w_in2;
   logic            w_busy;
   logic            w_valid;
   logic [XLEN-1:0] w_rslt;

   modport master (
      output w_start, w_fct3, w_in1, w_in2,
      input  w_busy, w_valid, w_rslt
   );

   modport slave (
      input  w_start, w_fct3, w_in1, w_in2,
      output w_busy, w_valid, w_rslt
   );
endinterface

// File: rtl/m_muldiv_iter.sv
// Iterative RV M-extension unit: shift-add multiply retiring MUL_STEP bits per
// cycle and a radix-2 restoring divide, both on operand magnitudes.
module m_muldiv_iter #(
   parameter int XLEN      = 32,
   parameter int MUL_STEP  = 2,
   parameter int FAST_DIV0 = 1
) (
   input  logic           w_clk,
   input  logic           w_rst,
   m_muldiv_iter_if.slave bus
);
   localparam int              CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
   localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;
   state_t state_reg, state_next;

   logic [1:0]        op_reg;
   logic [CW-1:0]     cnt_reg;
   logic              neg_p_reg, neg_q_reg, neg_r_reg;
   logic [2*XLEN-1:0] prod_reg, mcand_reg;
   logic [XLEN-1:0]   mplier_reg;
   logic [XLEN-1:0]   rem_reg, quo_reg, dvs_reg;
   logic [XLEN-1:0]   rslt_reg;
   logic              busy, valid;

   logic              signed1, signed2, sign1, sign2, div0, ovf, fast_hit;
   logic [XLEN-1:0]   mag1, mag2, fast_rslt;

   always_comb begin
      signed1   = (bus.w_fct3 == 3'd1) || (bus.w_fct3 == 3'd2) ||
                  (bus.w_fct3 == 3'd4) || (bus.w_fct3 == 3'd6);
      signed2   = (bus.w_fct3 == 3'd1) || (bus.w_fct3 == 3'd4) || (bus.w_fct3 == 3'd6);
      sign1     = signed1 && bus.w_in1[XLEN-1];
      sign2     = signed2 && bus.w_in2[XLEN-1];
      mag1      = sign1 ? -bus.w_in1 : bus.w_in1;
      mag2      = sign2 ? -bus.w_in2 : bus.w_in2;
      div0      = (bus.w_in2 == '0);
      // Overflow only exists for the signed divides (funct3 4 and 6).
      ovf       = !bus.w_fct3[0] && (bus.w_in1 == MIN_NEG) && (bus.w_in2 == '1);
      fast_hit  = (FAST_DIV0 != 0) && bus.w_fct3[2] && (div0 || ovf);
      if (bus.w_fct3[1]) begin
         fast_rslt = div0 ? bus.w_in1 : '0;
      end else begin
         fast_rslt = div0 ? '1 : bus.w_in1;
      end
   end

   logic [2*XLEN-1:0] pp [MUL_STEP];
   logic [2*XLEN-1:0] prod_sum, prod_fin;
   logic [XLEN-1:0]   mul_rslt;

   for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
   end

   always_comb begin
      prod_sum = prod_reg;
      for (int i = 0; i < MUL_STEP; i++) begin
         prod_sum = prod_sum + pp[i];
      end
      prod_fin = neg_p_reg ? -prod_sum : prod_sum;
      mul_rslt = (op_reg == 2'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
   end

   logic [XLEN:0]   div_shift, div_diff;
   logic            div_take;
   logic [XLEN-1:0] rem_step, quo_step, div_rslt;

   // The borrow out of the trial subtraction decides the quotient bit.
   always_comb begin
      div_shift = {rem_reg, quo_reg[XLEN-1]};
      div_diff  = div_shift - {1'b0, dvs_reg};
      div_take  = !div_diff[XLEN];
      rem_step  = div_take ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      quo_step  = {quo_reg[XLEN-2:0], div_take};
      if (op_reg[1]) begin
         div_rslt = neg_r_reg ? -rem_step : rem_step;
      end else begin
         div_rslt = neg_q_reg ? -quo_step : quo_step;
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      valid      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (bus.w_start) begin
               if (fast_hit) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = bus.w_fct3[2] ? ST_DIV : ST_MUL;
               end
            end
         end
         ST_MUL:  if (cnt_reg == MUL_LAST) state_next = ST_DONE;
         ST_DIV:  if (cnt_reg == DIV_LAST) state_next = ST_DONE;
         ST_DONE: begin
            valid      = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Results are registered on the edge that enters DONE so they coincide
   // with the valid pulse.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         op_reg     <= '0;
         cnt_reg    <= '0;
         neg_p_reg  <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         prod_reg   <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         dvs_reg    <= '0;
         rslt_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: if (bus.w_start) begin
               op_reg     <= bus.w_fct3[1:0];
               cnt_reg    <= '0;
               neg_p_reg  <= sign1 ^ sign2;
               neg_q_reg  <= (sign1 ^ sign2) && !div0;
               neg_r_reg  <= sign1;
               prod_reg   <= '0;
               mcand_reg  <= {{XLEN{1'b0}}, mag1};
               mplier_reg <= mag2;
               rem_reg    <= '0;
               quo_reg    <= mag1;
               dvs_reg    <= mag2;
               if (fast_hit) rslt_reg <= fast_rslt;
            end
            ST_MUL: begin
               prod_reg   <= prod_sum;
               mcand_reg  <= mcand_reg << MUL_STEP;
               mplier_reg <= mplier_reg >> MUL_STEP;
               cnt_reg    <= cnt_reg + 1'b1;
               if (cnt_reg == MUL_LAST) rslt_reg <= mul_rslt;
            end
            ST_DIV: begin
               rem_reg <= rem_step;
               quo_reg <= quo_step;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == DIV_LAST) rslt_reg <= div_rslt;
            end
            default: ;
         endcase
      end
   end

   assign bus.w_busy  = busy;
   assign bus.w_valid = valid;
   assign bus.w_rslt  = rslt_reg;
endmodule
